imsic_intp_file: RTL and testbench



---
 rtl/imsic_pkg.sv | 19 +
 rtl/fifo_v3.sv | 64 ++++++
 rtl/imsic_intp_file.sv | 201 ++++++++++++++++++++
 tb/tb_imsic_intp_file.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_pkg.sv
// Shared definitions for the IMSIC interrupt-file slice: siselect map and MSI ingress entry.
package imsic_pkg;

  // siselect values of the indirectly accessed interrupt-file registers
  localparam logic [31:0] EIDELIVERY  = 32'h0000_0070;
  localparam logic [31:0] EITHRESHOLD = 32'h0000_0072;
  localparam logic [31:0] EIP_BASE    = 32'h0000_0080;
  localparam logic [31:0] EIE_BASE    = 32'h0000_00C0;

  // Wide enough for any realistic interrupt-file count; out-of-range files are dropped at drain
  localparam int unsigned MSI_FILE_W = 8;

  // One buffered MSI write: target file and the identity carried in the MSI data
  typedef struct packed {
    logic [MSI_FILE_W-1:0] file;
    logic [31:0]           id;
  } msi_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with asynchronous active-low reset and synchronous flush.
module fifo_v3 #(
  parameter int unsigned DEPTH = 2,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dtype          mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (cnt_r == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_r == '0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign data_o    = mem_r[rd_ptr_r];

  // Read/write pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (flush_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? '0 : wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? '0 : rd_ptr_r + AW'(1'b1);
      end
      cnt_r <= cnt_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

  // Entry storage, written at the tail on every accepted push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

endmodule

// File: rtl/imsic_intp_file.sv
// Per-hart IMSIC interrupt files (M, S, VS): CSR access, claim, MSI ingress, xtopei and irq lines.
module imsic_intp_file
  import imsic_pkg::*;
#(
  parameter  int unsigned NrSources      = 64,
  parameter  int unsigned NrSourcesW     = $clog2(NrSources),
  parameter  int unsigned NrVSIntpFiles  = 1,
  parameter  int unsigned NrVSIntpFilesW = $clog2(NrVSIntpFiles + 1),
  parameter  int unsigned XLEN           = 64,
  localparam int unsigned NrIntpFiles    = 2 + NrVSIntpFiles,
  localparam int unsigned FileW          = $clog2(NrIntpFiles)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [1:0]                              imsic_priv_lvl_i,
  input  logic [NrVSIntpFilesW:0]                 imsic_vgein_i,
  input  logic [31:0]                             imsic_addr_i,
  input  logic [XLEN-1:0]                         imsic_data_i,
  input  logic                                    imsic_we_i,
  input  logic                                    imsic_claim_i,
  output logic [XLEN-1:0]                         imsic_data_o,
  output logic                                    imsic_exception_o,
  output logic [NrIntpFiles-1:0][NrSourcesW-1:0]  imsic_xtopei_o,
  output logic [NrIntpFiles-1:0]                  irq_o,
  input  logic                                    msi_valid_i,
  output logic                                    msi_ready_o,
  input  logic [FileW-1:0]                        msi_file_i,
  input  logic [31:0]                             msi_id_i
);

  localparam int unsigned NrWords = NrSources / XLEN;
  localparam logic [NrSources-1:0] OneHot = {{(NrSources-1){1'b0}}, 1'b1};

  // Architectural interrupt-file state
  logic [NrIntpFiles-1:0][NrSources-1:0]  eip_r, eip_d;
  logic [NrIntpFiles-1:0][NrSources-1:0]  eie_r, eie_d;
  logic [NrIntpFiles-1:0]                 del_r, del_d;
  logic [NrIntpFiles-1:0][NrSourcesW-1:0] thr_r, thr_d;

  // Access decode
  logic             priv_ok_s;
  logic [FileW-1:0] sel_file_s;
  logic             is_del_s, is_thr_s, is_eip_s, is_eie_s;
  logic [5:0]       word_k_s;
  logic             word_ok_s;
  logic             exc_s;
  logic [NrIntpFiles-1:0] csr_hit_s;
  logic [XLEN-1:0]  rdata_s;

  // Priority and ingress
  logic [NrIntpFiles-1:0][NrSourcesW-1:0] top_s;
  msi_entry_t msi_in_s, head_s;
  logic       fifo_full_s, fifo_empty_s;
  logic       stall_s, drain_s, head_ok_s;

  // Map privilege and vgein to a target file; guest files exist only for S-level accesses
  always_comb begin
    priv_ok_s  = 1'b0;
    sel_file_s = '0;
    case (imsic_priv_lvl_i)
      2'd3: begin
        priv_ok_s  = 1'b1;
        sel_file_s = '0;
      end
      2'd1: begin
        priv_ok_s  = (int'(imsic_vgein_i) <= int'(NrVSIntpFiles));
        sel_file_s = FileW'(imsic_vgein_i) + FileW'(1'b1);
      end
      default: begin
        priv_ok_s  = 1'b0;
        sel_file_s = '0;
      end
    endcase
  end

  assign is_del_s  = (imsic_addr_i == EIDELIVERY);
  assign is_thr_s  = (imsic_addr_i == EITHRESHOLD);
  assign is_eip_s  = (imsic_addr_i[31:6] == EIP_BASE[31:6]);
  assign is_eie_s  = (imsic_addr_i[31:6] == EIE_BASE[31:6]);
  assign word_k_s  = imsic_addr_i[5:0];
  // k counts 32-bit words; an XLEN-wide access must start on an XLEN boundary
  assign word_ok_s = (word_k_s[0] == 1'b0) && (int'(word_k_s) < int'(NrSources / 32));
  assign exc_s     = ~priv_ok_s | ~(is_del_s | is_thr_s | ((is_eip_s | is_eie_s) & word_ok_s));

  // One-hot of the file a legal access targets
  always_comb begin
    csr_hit_s = '0;
    for (int f = 0; f < int'(NrIntpFiles); f++) begin
      csr_hit_s[f] = ~exc_s & (sel_file_s == FileW'(f));
    end
  end

  // Combinational read mux from registered state; illegal accesses read zero
  always_comb begin
    rdata_s = '0;
    for (int f = 0; f < int'(NrIntpFiles); f++) begin
      for (int w = 0; w < int'(NrWords); w++) begin
        if (csr_hit_s[f] && (is_eip_s || is_eie_s) && word_k_s == 6'(w * XLEN / 32)) begin
          rdata_s = is_eip_s ? eip_r[f][w*XLEN +: XLEN] : eie_r[f][w*XLEN +: XLEN];
        end else begin
          rdata_s = rdata_s;
        end
      end
      if (csr_hit_s[f] && is_del_s) begin
        rdata_s = XLEN'(del_r[f]);
      end else if (csr_hit_s[f] && is_thr_s) begin
        rdata_s = XLEN'(thr_r[f]);
      end else begin
        rdata_s = rdata_s;
      end
    end
  end

  assign imsic_data_o      = rdata_s;
  assign imsic_exception_o = exc_s;

  // Lowest enabled-pending identity per file and the resulting level interrupt
  for (genvar gf = 0; gf < int'(NrIntpFiles); gf++) begin : g_file
    logic [NrSourcesW-1:0] enc_s;

    // Scan downward so the smallest hit is the one left standing
    always_comb begin
      enc_s = '0;
      for (int i = int'(NrSources) - 1; i >= 1; i--) begin
        enc_s = (eip_r[gf][i] & eie_r[gf][i]) ? NrSourcesW'(i) : enc_s;
      end
    end

    assign top_s[gf] = enc_s;
    assign irq_o[gf] = del_r[gf] & (enc_s != '0) &
                       ((thr_r[gf] == '0) | (enc_s < thr_r[gf]));
  end

  assign imsic_xtopei_o = top_s;

  // MSI ingress buffer; the drain yields to CSR writes of eip so the two never collide
  assign msi_in_s    = '{file: MSI_FILE_W'(msi_file_i), id: msi_id_i};
  assign msi_ready_o = ~fifo_full_s;
  assign stall_s     = imsic_we_i & ~exc_s & is_eip_s;
  assign drain_s     = ~fifo_empty_s & ~stall_s;
  assign head_ok_s   = (head_s.id != 32'd0) && (head_s.id < 32'(NrSources)) &&
                       (head_s.file < MSI_FILE_W'(NrIntpFiles));

  fifo_v3 #(
    .DEPTH (2),
    .dtype (msi_entry_t)
  ) i_msi_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .data_i  (msi_in_s),
    .push_i  (msi_valid_i),
    .data_o  (head_s),
    .pop_i   (drain_s)
  );

  // Next state: CSR write, then claim clear, then MSI set so a new arrival always survives
  always_comb begin
    eip_d = eip_r;
    eie_d = eie_r;
    del_d = del_r;
    thr_d = thr_r;
    for (int f = 0; f < int'(NrIntpFiles); f++) begin
      del_d[f] = (csr_hit_s[f] && imsic_we_i && is_del_s) ? imsic_data_i[0] : del_r[f];
      thr_d[f] = (csr_hit_s[f] && imsic_we_i && is_thr_s) ? imsic_data_i[NrSourcesW-1:0] : thr_r[f];
      for (int w = 0; w < int'(NrWords); w++) begin
        eip_d[f][w*XLEN +: XLEN] =
          (csr_hit_s[f] && imsic_we_i && is_eip_s && word_k_s == 6'(w * XLEN / 32)) ?
          imsic_data_i : eip_r[f][w*XLEN +: XLEN];
        eie_d[f][w*XLEN +: XLEN] =
          (csr_hit_s[f] && imsic_we_i && is_eie_s && word_k_s == 6'(w * XLEN / 32)) ?
          imsic_data_i : eie_r[f][w*XLEN +: XLEN];
      end
      eip_d[f] = eip_d[f] &
                 ~((csr_hit_s[f] && imsic_claim_i && top_s[f] != '0) ? (OneHot << top_s[f]) : '0);
      eip_d[f] = eip_d[f] |
                 ((drain_s && head_ok_s && head_s.file == MSI_FILE_W'(f)) ?
                  (OneHot << head_s.id[NrSourcesW-1:0]) : '0);
      eip_d[f][0] = 1'b0;
      eie_d[f][0] = 1'b0;
    end
  end

  // Interrupt-file state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eip_r <= '0;
      eie_r <= '0;
      del_r <= '0;
      thr_r <= '0;
    end else begin
      eip_r <= eip_d;
      eie_r <= eie_d;
      del_r <= del_d;
      thr_r <= thr_d;
    end
  end

endmodule

// File: tb/tb_imsic_intp_file.sv
// Self-checking bench for imsic_intp_file: directed scenarios then random traffic vs. a reference model.
module tb_imsic_intp_file;

  localparam int NS  = 64;
  localparam int NSW = 6;
  localparam int NVS = 1;
  localparam int NF  = 3;
  localparam int FW  = 2;
  localparam int VW  = 2;

  logic                     clk = 1'b0;
  logic                     rst_ni;
  logic [1:0]               priv;
  logic [VW-1:0]            vgein;
  logic [31:0]              addr;
  logic [63:0]              wdata;
  logic                     we;
  logic                     claim;
  logic [63:0]              rdata;
  logic                     exc;
  logic [NF-1:0][NSW-1:0]   top;
  logic [NF-1:0]            irq;
  logic                     msi_valid;
  logic                     msi_ready;
  logic [FW-1:0]            msi_file;
  logic [31:0]              msi_id;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: plain bit arrays per file plus a queue for the ingress buffer
  bit     m_eip [NF][NS];
  bit     m_eie [NF][NS];
  bit     m_del [NF];
  int     m_thr [NF];
  int     q_file[$];
  longint q_id  [$];

  logic [31:0] addr_tab [8] = '{32'h70, 32'h72, 32'h80, 32'hC0, 32'h81, 32'h82, 32'hC0, 32'h71};

  imsic_intp_file dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .imsic_priv_lvl_i  (priv),
    .imsic_vgein_i     (vgein),
    .imsic_addr_i      (addr),
    .imsic_data_i      (wdata),
    .imsic_we_i        (we),
    .imsic_claim_i     (claim),
    .imsic_data_o      (rdata),
    .imsic_exception_o (exc),
    .imsic_xtopei_o    (top),
    .irq_o             (irq),
    .msi_valid_i       (msi_valid),
    .msi_ready_o       (msi_ready),
    .msi_file_i        (msi_file),
    .msi_id_i          (msi_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_sel();
    if (priv == 2'd3) return 0;
    if (priv == 2'd1 && int'(vgein) <= NVS) return 1 + int'(vgein);
    return -1;
  endfunction

  function automatic bit m_legal();
    longint a = longint'(addr);
    longint k;
    if (m_sel() < 0) return 1'b0;
    if (a == 112 || a == 114) return 1'b1;
    if (a >= 128 && a < 256) begin
      k = a % 64;
      return (k % 2 == 0) && (k < NS / 32);
    end
    return 1'b0;
  endfunction

  function automatic int m_top(input int f);
    for (int i = 1; i < NS; i++) begin
      if (m_eip[f][i] && m_eie[f][i]) return i;
    end
    return 0;
  endfunction

  function automatic bit m_irq(input int f);
    int t = m_top(f);
    return m_del[f] && t != 0 && (m_thr[f] == 0 || t < m_thr[f]);
  endfunction

  function automatic logic [63:0] m_read();
    logic [63:0] r = 64'd0;
    longint a = longint'(addr);
    int f = m_sel();
    int base;
    if (!m_legal()) return 64'd0;
    if (a == 112) return 64'(m_del[f]);
    if (a == 114) return 64'(m_thr[f]);
    base = 32 * int'(a % 64);
    for (int j = 0; j < 64; j++) r[j] = (a < 192) ? m_eip[f][base + j] : m_eie[f][base + j];
    return r;
  endfunction

  task automatic m_reset();
    for (int f = 0; f < NF; f++) begin
      m_del[f] = 1'b0;
      m_thr[f] = 0;
      for (int i = 0; i < NS; i++) begin
        m_eip[f][i] = 1'b0;
        m_eie[f][i] = 1'b0;
      end
    end
    q_file.delete();
    q_id.delete();
  endtask

  // Advance the model over one rising edge using the inputs currently applied
  task automatic model_edge();
    longint a = longint'(addr);
    bit lg = m_legal();
    int f = m_sel();
    int tops [NF];
    bit acc, stall;
    int hf;
    longint hid;
    int base;
    if (!rst_ni) return;
    for (int ff = 0; ff < NF; ff++) tops[ff] = m_top(ff);
    acc   = msi_valid && (q_file.size() < 2);
    stall = we && lg && a >= 128 && a < 192;
    if (lg && we) begin
      if (a == 112) m_del[f] = wdata[0];
      else if (a == 114) m_thr[f] = int'(wdata[NSW-1:0]);
      else begin
        base = 32 * int'(a % 64);
        for (int j = 0; j < 64; j++) begin
          if (a < 192) m_eip[f][base + j] = wdata[j];
          else m_eie[f][base + j] = wdata[j];
        end
      end
    end
    if (lg && claim && tops[f] != 0) m_eip[f][tops[f]] = 1'b0;
    if (q_file.size() > 0 && !stall) begin
      hf  = q_file.pop_front();
      hid = q_id.pop_front();
      if (hf < NF && hid > 0 && hid < NS) m_eip[hf][int'(hid)] = 1'b1;
    end
    for (int ff = 0; ff < NF; ff++) begin
      m_eip[ff][0] = 1'b0;
      m_eie[ff][0] = 1'b0;
    end
    if (acc) begin
      q_file.push_back(int'(msi_file));
      q_id.push_back(longint'(msi_id));
    end
  endtask

  task automatic check_all();
    chk("exception", 64'(exc), m_legal() ? 64'd0 : 64'd1);
    chk("rdata", rdata, m_read());
    chk("msi_ready", 64'(msi_ready), (q_file.size() < 2) ? 64'd1 : 64'd0);
    for (int f = 0; f < NF; f++) begin
      chk($sformatf("xtopei%0d", f), 64'(top[f]), 64'(m_top(f)));
      chk($sformatf("irq%0d", f), 64'(irq[f]), 64'(m_irq(f)));
    end
  endtask

  // Check on the falling edge, update the model, then return just after the rising edge
  task automatic step();
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    claim = 1'b0;
    msi_valid = 1'b0;
  endtask

  task automatic csr_wr(input logic [31:0] a, input logic [63:0] d);
    priv = 2'd3; vgein = '0; addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic send_msi(input int f, input int id);
    msi_valid = 1'b1; msi_file = FW'(f); msi_id = 32'(id);
    step();
    msi_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [63:0] exp);
    priv = 2'd3; vgein = '0; addr = a; we = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst_ni = 1'b0; priv = 2'd3; vgein = '0; addr = 32'h70; wdata = 64'd0;
    msi_file = '0; msi_id = 32'd0;
    idle();
    m_reset();
    step(); step();
    rst_ni = 1'b1;
    chk("rst_ready", 64'(msi_ready), 64'd1);
    chk("rst_irq", 64'(irq), 64'd0);
    rd_chk("rst_del", 32'h70, 64'd0);
    rd_chk("rst_eip", 32'h80, 64'd0);

    // Delivery to the M file
    csr_wr(32'h70, 64'd1);
    csr_wr(32'hC0, 64'h4);
    send_msi(0, 2);
    chk("deliv_latency", 64'(top[0]), 64'd0);
    step();
    chk("deliv_top0", 64'(top[0]), 64'd2);
    chk("deliv_irq0", 64'(irq[0]), 64'd1);
    chk("deliv_top1", 64'(top[1]), 64'd0);

    // Threshold behaviour
    csr_wr(32'h72, 64'd2);
    chk("thr2_irq", 64'(irq[0]), 64'd0);
    csr_wr(32'h72, 64'd3);
    chk("thr3_irq", 64'(irq[0]), 64'd1);
    csr_wr(32'h72, 64'd0);
    chk("thr0_irq", 64'(irq[0]), 64'd1);

    // Claim, and claim racing a new arrival of the same identity
    csr_wr(32'hC0, 64'h24);
    send_msi(0, 5);
    step();
    chk("claim_top_a", 64'(top[0]), 64'd2);
    addr = 32'h70; claim = 1'b1;
    step();
    claim = 1'b0;
    chk("claim_top_b", 64'(top[0]), 64'd5);
    send_msi(0, 5);
    addr = 32'h70; claim = 1'b1;
    step();
    claim = 1'b0;
    chk("claim_race", 64'(top[0]), 64'd5);

    // Backpressure while eip writes stall the drain
    priv = 2'd3; addr = 32'h80; wdata = 64'd0; we = 1'b1;
    msi_valid = 1'b1; msi_file = '0; msi_id = 32'd10;
    step();
    msi_id = 32'd11;
    step();
    msi_id = 32'd12;
    chk("bp_full", 64'(msi_ready), 64'd0);
    step(); step();
    we = 1'b0;
    chk("bp_still_full", 64'(msi_ready), 64'd0);
    step();
    chk("bp_ready_again", 64'(msi_ready), 64'd1);
    step();
    msi_valid = 1'b0;
    step(); step(); step();
    rd_chk("bp_eip", 32'h80, 64'h1C00);

    // Illegal accesses and dropped MSIs
    priv = 2'd3; addr = 32'h81; wdata = '1; we = 1'b1; #1;
    chk("ill_odd_k", 64'(exc), 64'd1);
    step();
    priv = 2'd0; addr = 32'h70; #1;
    chk("ill_priv0", 64'(exc), 64'd1);
    step();
    priv = 2'd1; vgein = VW'(NVS + 1); #1;
    chk("ill_vgein", 64'(exc), 64'd1);
    step();
    we = 1'b0; priv = 2'd3; vgein = '0; wdata = 64'd64; #1;
    chk("legal_read", 64'(exc), 64'd0);
    send_msi(0, 0);
    send_msi(0, 64);
    step(); step();
    rd_chk("drop_eip", 32'h80, 64'h1C00);
    rd_chk("ill_del", 32'h70, 64'd1);

    // Asynchronous reset with a full ingress buffer and live interrupts
    csr_wr(32'hC0, '1);
    chk("pre_rst_irq", 64'(irq[0]), 64'd1);
    priv = 2'd3; addr = 32'h80; wdata = 64'h1C00; we = 1'b1;
    msi_valid = 1'b1; msi_file = '0; msi_id = 32'd20;
    step();
    msi_id = 32'd21;
    step();
    chk("pre_rst_full", 64'(msi_ready), 64'd0);
    #2;
    rst_ni = 1'b0;
    idle();
    #1;
    m_reset();
    chk("rst_async_irq", 64'(irq), 64'd0);
    chk("rst_async_top", 64'(top), 64'd0);
    chk("rst_async_ready", 64'(msi_ready), 64'd1);
    step(); step();
    rst_ni = 1'b1;
    step(); step(); step();
    rd_chk("post_rst_eip", 32'h80, 64'd0);

    // Random traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      priv      = 2'($urandom_range(0, 3));
      vgein     = VW'($urandom_range(0, 3));
      addr      = addr_tab[$urandom_range(0, 7)];
      wdata     = {$urandom, $urandom};
      we        = ($urandom_range(0, 3) == 0);
      claim     = ($urandom_range(0, 4) == 0);
      msi_valid = ($urandom_range(0, 1) == 1);
      msi_file  = FW'($urandom_range(0, 3));
      msi_id    = 32'($urandom_range(0, 70));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
